// File: rtl/c3lib_ckdiv_inv_prog.sv
// Programmable glitch-free clock divider with runtime polarity; outputs fully registered on clk.
// Config is shadowed and only takes effect on a period boundary (wrap edge, or any edge while idle).
module c3lib_ckdiv_inv_prog #(
   parameter int   DIV_W       = 4,
   parameter int   DEFAULT_DIV = 2,
   parameter logic DEFAULT_INV = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clk_en,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic             cfg_inv,
   input  logic             cfg_load,
   output logic             cfg_ack,
   output logic             busy,
   output logic             clk_out
);

   typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

   localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
   localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);
   localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

   state_t           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             inv_q, inv_d;
   logic [DIV_W-1:0] sdiv_q, sdiv_d;
   logic             sinv_q, sinv_d;
   logic             pend_q, pend_d;
   logic             ack_q, ack_d;
   logic             out_q, out_d;

   logic             wrap;
   logic             boundary;
   logic             apply;
   logic             inv_nxt;
   logic [DIV_W-1:0] cnt_inc;
   logic [DIV_W-1:0] half;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      div_d    = div_q;
      inv_d    = inv_q;
      sdiv_d   = sdiv_q;
      sinv_d   = sinv_q;
      pend_d   = pend_q;
      ack_d    = 1'b0;
      out_d    = out_q;

      wrap     = (cnt_q == (div_q - ONE));
      boundary = (state_q == IDLE) || wrap;
      apply    = pend_q && boundary;
      inv_nxt  = apply ? sinv_q : inv_q;
      cnt_inc  = cnt_q + ONE;
      half     = div_q >> 1;

      // Apply the old shadow before capturing a simultaneous load, so the new one stays pending.
      if (apply) begin
         div_d  = sdiv_q;
         inv_d  = sinv_q;
         pend_d = 1'b0;
         ack_d  = 1'b1;
      end
      if (cfg_load) begin
         sdiv_d = (cfg_div < TWO) ? TWO : cfg_div;
         sinv_d = cfg_inv;
         pend_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (clk_en) begin
               state_d = RUN;
               out_d   = ~inv_nxt;
            end else begin
               out_d   = inv_nxt;
            end
         end
         RUN, STOP: begin
            if (wrap) begin
               cnt_d = '0;
               if (clk_en) begin
                  state_d = RUN;
                  out_d   = ~inv_nxt;
               end else begin
                  state_d = IDLE;
                  out_d   = inv_nxt;
               end
            end else begin
               // Mid-period the count always continues; clk_en only decides whether the wrap restarts.
               cnt_d   = cnt_inc;
               state_d = clk_en ? RUN : STOP;
               out_d   = (cnt_inc < half) ^ inv_q;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            out_d   = inv_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         div_q   <= DEF_DIV;
         inv_q   <= DEFAULT_INV;
         sdiv_q  <= DEF_DIV;
         sinv_q  <= DEFAULT_INV;
         pend_q  <= 1'b0;
         ack_q   <= 1'b0;
         out_q   <= DEFAULT_INV;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         inv_q   <= inv_d;
         sdiv_q  <= sdiv_d;
         sinv_q  <= sinv_d;
         pend_q  <= pend_d;
         ack_q   <= ack_d;
         out_q   <= out_d;
      end
   end

   assign cfg_ack = ack_q;
   assign busy    = (state_q != IDLE);
   assign clk_out = out_q;

endmodule

// File: tb/tb_c3lib_ckdiv_inv_prog.sv
// Bench for c3lib_ckdiv_inv_prog: period-position reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_c3lib_ckdiv_inv_prog;

   logic       clk;
   logic       rst_n;
   logic       clk_en;
   logic [3:0] cfg_div;
   logic       cfg_inv;
   logic       cfg_load;
   logic       cfg_ack;
   logic       busy;
   logic       clk_out;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 0;

   // reference model: period position plus active/shadow config
   int   m_k, m_n, m_sn;
   bit   m_run, m_inv, m_sinv, m_pend;
   logic e_out, e_busy, e_ack;

   c3lib_ckdiv_inv_prog #(.DIV_W(4), .DEFAULT_DIV(2), .DEFAULT_INV(1'b0)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clk_en   (clk_en),
      .cfg_div  (cfg_div),
      .cfg_inv  (cfg_inv),
      .cfg_load (cfg_load),
      .cfg_ack  (cfg_ack),
      .busy     (busy),
      .clk_out  (clk_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_k = 0; m_n = 2; m_sn = 2;
            m_run = 0; m_inv = 0; m_sinv = 0; m_pend = 0;
            e_out = 1'b0; e_busy = 1'b0; e_ack = 1'b0;
         end else begin
            bit boundary;
            boundary = !m_run || (m_k == m_n - 1);
            e_ack = m_pend && boundary;
            if (m_pend && boundary) begin
               m_n    = m_sn;
               m_inv  = m_sinv;
               m_pend = 0;
            end
            if (cfg_load) begin
               m_sn   = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
               m_sinv = cfg_inv;
               m_pend = 1;
            end
            if (boundary) begin
               m_run = clk_en;
               m_k   = 0;
            end else begin
               m_k   = m_k + 1;
            end
            e_busy = m_run;
            e_out  = m_run ? ((m_k < m_n / 2) ^ m_inv) : m_inv;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            chk("model_clk_out", clk_out, e_out);
            chk("model_busy", busy, e_busy);
            chk("model_cfg_ack", cfg_ack, e_ack);
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
      cfg_load = 1'b0;
   endtask

   task automatic wait_k(input int t);
      int b;
      b = 0;
      while ((m_k != t || !m_run) && b < 40) begin
         step();
         b++;
      end
      if (b >= 40) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_k: period position %0d not reached within 40 cycles", t);
      end
   endtask

   initial begin
      rst_n = 1'b0; clk_en = 1'b0; cfg_div = 4'd0; cfg_inv = 1'b0; cfg_load = 1'b0;
      @(posedge clk);
      cmp_en = 1;
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      chk("reset_clk_out", clk_out, 0);
      chk("reset_busy", busy, 0);
      chk("reset_cfg_ack", cfg_ack, 0);

      // start at N=2, then reprogram to N=5 mid-period
      for (int i = 0; i < 3; i++) begin
         step(); chk("idle_level", clk_out, 0);
      end
      clk_en = 1'b1;
      step(); chk("start_k0", clk_out, 1); chk("start_busy", busy, 1);
      step(); chk("n2_k1", clk_out, 0);
      step(); chk("n2_k0", clk_out, 1);
      cfg_div = 4'd5; cfg_load = 1'b1;
      step(); chk("n2_k1_pending", clk_out, 0); chk("no_ack_midperiod", cfg_ack, 0);
      step(); chk("n5_k0", clk_out, 1); chk("ack_after_wrap", cfg_ack, 1);
      step(); chk("n5_k1", clk_out, 1); chk("ack_single", cfg_ack, 0);
      step(); chk("n5_k2", clk_out, 0);
      step(); chk("n5_k3", clk_out, 0);
      step(); chk("n5_k4", clk_out, 0);
      step(); chk("n5_next_k0", clk_out, 1);
      step(); chk("n5_next_k1", clk_out, 1);
      step(); chk("n5_next_k2", clk_out, 0);

      // N=4 drain: drop at k=1, period completes, then idles low
      cfg_div = 4'd4; cfg_load = 1'b1;
      step();
      repeat (6) step();
      wait_k(1);
      clk_en = 1'b0;
      repeat (4) step();
      chk("drain_idle_busy", busy, 0);
      chk("drain_idle_level", clk_out, 0);

      // drop then re-assert before the wrap: no gap
      clk_en = 1'b1;
      step();
      wait_k(1);
      clk_en = 1'b0;
      step();
      clk_en = 1'b1;
      step();
      step();
      chk("resume_busy", busy, 1);
      chk("resume_k0", clk_out, 1);

      // inverted N=3, then stop and idle high
      cfg_div = 4'd3; cfg_inv = 1'b1; cfg_load = 1'b1;
      step();
      repeat (10) step();
      clk_en = 1'b0;
      repeat (5) step();
      chk("inv_idle_level", clk_out, 1);
      chk("inv_idle_busy", busy, 0);

      // two loads in one N=8 period, then a ratio of 0
      cfg_div = 4'd8; cfg_inv = 1'b0; cfg_load = 1'b1;
      step();
      clk_en = 1'b1;
      step();
      wait_k(1);
      cfg_div = 4'd6; cfg_load = 1'b1;
      step();
      cfg_div = 4'd3; cfg_load = 1'b1;
      step();
      repeat (14) step();
      cfg_div = 4'd0; cfg_load = 1'b1;
      step();
      repeat (8) step();

      // async reset at k=2 of N=6 with a load pending
      cfg_div = 4'd6; cfg_load = 1'b1;
      step();
      repeat (8) step();
      wait_k(1);
      cfg_div = 4'd3; cfg_load = 1'b1;
      step();
      chk("pre_reset_k2_high", clk_out, 1);
      rst_n = 1'b0;
      #1;
      chk("async_reset_clk_out", clk_out, 0);
      chk("async_reset_busy", busy, 0);
      chk("async_reset_ack", cfg_ack, 0);
      clk_en = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (4) step();
      clk_en = 1'b1;
      step(); chk("post_reset_k0", clk_out, 1);
      step(); chk("post_reset_k1", clk_out, 0);
      step(); chk("post_reset_default_n2", clk_out, 1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) clk_en = ~clk_en;
         cfg_load = ($urandom_range(0, 9) == 0);
         cfg_div  = 4'($urandom_range(0, 15));
         cfg_inv  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 599) == 0) begin
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
         end else begin
            step();
         end
      end

      cmp_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
